regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter INIT_CLEAR, default 1, meaning 1 = zero-fill registers 1..31 after reset and 0 = skip the fill.
REQ-002 SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have input req_valid, 3 bits; bit i = requester i has a write pending (0 = ALU writeback, 1 = load unit, 2 = mul/div).
REQ-005 SHALL have output req_ready, 3 bits; bit i = requester i's write is accepted this cycle.
REQ-006 SHALL have input req_addr, 15 bits; requester i's destination register is in bits [5i+4:5i].
REQ-007 SHALL have input req_data, 96 bits; requester i's write data is in bits [32i+31:32i].
REQ-008 SHALL have outputs rf_we (1 bit), rf_wa (5 bits) and rf_wd (32 bits), which drive the register file write port (we/wa/wd) directly.
REQ-009 SHALL have output init_done, 1 bit, high once the arbiter is in RUN.
REQ-010 SHALL have output last_grant, 2 bits, the index of the most recently accepted requester.

Function
REQ-011 SHALL have a state machine with two states: INIT (zero-fill) and RUN (arbitrate).
REQ-012 SHALL, in INIT, on each edge set rf_we=1, rf_wa=cnt, rf_wd=0 and cnt++, with cnt starting at 1.
REQ-013 SHALL move to RUN on the edge that loads rf_wa=31, so that edge also sets init_done=1; INIT lasts exactly 31 edges.
REQ-014 SHALL, when INIT_CLEAR=0, skip zero-fill: the first edge after reset release enters RUN with init_done=1 and rf_we=0.
REQ-015 SHALL hold req_ready=0 while rst_n is low and throughout INIT.
REQ-016 SHALL arbitrate in RUN with a round-robin pointer ptr (0..2): search order ptr, ptr+1, ptr+2 (mod 3); the first requester with req_valid set is granted.
REQ-017 SHALL make req_ready one-hot or zero, combinational from req_valid and ptr; ready[i]=1 only if valid[i]=1.
REQ-018 SHALL complete a transfer on an edge where valid[i] & ready[i]; at that edge: ptr<=(i+1) mod 3, last_grant<=i, and rf_wa/rf_wd<=requester i's addr/data.
REQ-019 SHALL, at that same edge, set rf_we<=1, except rf_we<=0 when addr==0 (a write to x0 is accepted and dropped but still rotates ptr).
REQ-020 SHALL set rf_we<=0 on any RUN edge with no transfer, with rf_wa/rf_wd holding their values and ptr unchanged.
REQ-021 SHALL give a latency of exactly one cycle: accepted at edge N, rf_we high during cycle N..N+1, register written at edge N+1.
REQ-022 SHALL sustain one accepted write per cycle (throughput 1/cycle).
REQ-023 SHALL serialise simultaneous requests to the same address in grant order; the later grant wins the register.
REQ-024 SHALL leave a requester that drops valid before ready unpenalised and ungranted; ptr does not skip past it.
REQ-025 SHALL have requesters hold addr/data stable while valid is high and ready is low; the arbiter samples them only at the accepting edge.

Reset
REQ-026 SHALL, when rst_n is low, immediately set: rf_we=0, rf_wa=0, rf_wd=0, init_done=0, req_ready=0, last_grant=0, ptr=0, cnt=1, state=INIT.
REQ-027 SHALL, when reset is asserted mid-operation, drop any accepted-but-unwritten transfer (rf_we falls before the next edge) and restart INIT after release.
REQ-028 SHALL resume normal sequencing from the first rising edge after rst_n rises.

Verification
REQ-029 SHALL cover: reset release with INIT_CLEAR=1 -> rf_we=1 for 31 consecutive cycles with rf_wa=1..31 and rf_wd=0; init_done rises with rf_wa=31; req_ready=0 throughout; a register file readback of x1..x31 returns 0.
REQ-030 SHALL cover: in RUN, only req 1 valid with addr=5, data=0x0000000A -> req_ready=3'b010 in the same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xA; after the next edge rd of x5=0xA; last_grant=1, ptr=2.
REQ-031 SHALL cover: all three valid continuously from ptr=0 -> accepts in order 0,1,2,0,1,2, one per cycle, with rf_we high every cycle.
REQ-032 SHALL cover: req 2 valid with addr=0, data=0xFFFFFFFF -> req_ready[2]=1; next cycle rf_we=0; x0 reads 0; ptr=0.
REQ-033 SHALL cover: ptr=1, req 1 idle, reqs 0 and 2 valid -> req 2 granted first, then req 0.
REQ-034 SHALL cover: rst_n pulled low 2ns after acceptance of addr=7, data=0x55 -> rf_we falls immediately; x7 unchanged; INIT restarts with rf_wa=1 on the first edge after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for ALU/load/muldiv into the RF write port.
// Ports: clk, rst_n, req_valid/ready[3], req_addr[15], req_data[96],
//        rf_we/wa/wd, init_done, last_grant[2]. Zero-fills x1..x31 first.
module regfile_wb_arbiter #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        init_done,
  output logic [1:0]  last_grant
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic [1:0]  r_lg, w_lg_nxt;
  logic        r_we, w_we_nxt;
  logic [4:0]  r_wa, w_wa_nxt;
  logic [31:0] r_wd, w_wd_nxt;
  logic        r_done, w_done_nxt;

  logic [1:0]  w_ord1, w_ord2;
  logic [1:0]  w_gidx;
  logic        w_hit;
  logic [2:0]  w_ready;
  logic [4:0]  w_sel_addr;
  logic [31:0] w_sel_data;

  // Search order: ptr, ptr+1, ptr+2 (mod 3)
  assign w_ord1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
  assign w_ord2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

  always_comb begin
    w_hit  = 1'b0;
    w_gidx = 2'd0;
    if (r_state == S_RUN) begin
      if (req_valid[r_ptr]) begin
        w_hit  = 1'b1;
        w_gidx = r_ptr;
      end else if (req_valid[w_ord1]) begin
        w_hit  = 1'b1;
        w_gidx = w_ord1;
      end else if (req_valid[w_ord2]) begin
        w_hit  = 1'b1;
        w_gidx = w_ord2;
      end
    end
  end

  always_comb begin
    w_ready    = 3'b000;
    w_sel_addr = req_addr[4:0];
    w_sel_data = req_data[31:0];
    unique case (w_gidx)
      2'd1: begin
        w_sel_addr = req_addr[9:5];
        w_sel_data = req_data[63:32];
      end
      2'd2: begin
        w_sel_addr = req_addr[14:10];
        w_sel_data = req_data[95:64];
      end
      default: ;
    endcase
    if (w_hit) w_ready[w_gidx] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_lg_nxt    = r_lg;
    w_we_nxt    = 1'b0;
    w_wa_nxt    = r_wa;
    w_wd_nxt    = r_wd;
    w_done_nxt  = r_done;
    unique case (r_state)
      S_INIT: begin
        if (INIT_CLEAR) begin
          w_we_nxt  = 1'b1;
          w_wa_nxt  = r_cnt;
          w_wd_nxt  = 32'd0;
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_hit) begin
          // x0 writes are accepted but never reach the RF
          w_we_nxt  = (w_sel_addr != 5'd0);
          w_wa_nxt  = w_sel_addr;
          w_wd_nxt  = w_sel_data;
          w_lg_nxt  = w_gidx;
          w_ptr_nxt = (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= 5'd1;
      r_ptr   <= 2'd0;
      r_lg    <= 2'd0;
      r_we    <= 1'b0;
      r_wa    <= 5'd0;
      r_wd    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lg    <= w_lg_nxt;
      r_we    <= w_we_nxt;
      r_wa    <= w_wa_nxt;
      r_wd    <= w_wd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign req_ready  = w_ready;
  assign rf_we      = r_we;
  assign rf_wa      = r_wa;
  assign rf_wd      = r_wd;
  assign init_done  = r_done;
  assign last_grant = r_lg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
// Second instance covers the no-zero-fill configuration.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        init_done;
  logic [1:0]  last_grant;

  logic [2:0]  n_valid;
  logic [2:0]  n_ready;
  logic [14:0] n_addr;
  logic [95:0] n_data;
  logic        n_we;
  logic [4:0]  n_wa;
  logic [31:0] n_wd;
  logic        n_done;
  logic [1:0]  n_lg;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32] = '{default: 32'hBAD0_0BAD};

  regfile_wb_arbiter #(.INIT_CLEAR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .init_done(init_done), .last_grant(last_grant)
  );

  regfile_wb_arbiter #(.INIT_CLEAR(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_valid), .req_ready(n_ready),
    .req_addr(n_addr), .req_data(n_data),
    .rf_we(n_we), .rf_wa(n_wa), .rf_wd(n_wd),
    .init_done(n_done), .last_grant(n_lg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mem[a];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    n_valid   = 3'b000;
    n_addr    = '0;
    n_data    = '0;

    #12;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_wa", {27'd0, rf_wa}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_lg", {30'd0, last_grant}, 32'd0);
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_nc_done", {31'd0, n_done}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("init_ready0", {29'd0, req_ready}, 32'd0);

    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk("init_we", {31'd0, rf_we}, 32'd1);
      chk("init_wa", {27'd0, rf_wa}, 32'(k));
      chk("init_wd", rf_wd, 32'd0);
      chk("init_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
      if (k < 31) chk("init_ready", {29'd0, req_ready}, 32'd0);
      if (k == 1) begin
        chk("nc_done", {31'd0, n_done}, 32'd1);
        chk("nc_we", {31'd0, n_we}, 32'd0);
      end
      if (k == 31) req_valid = 3'b000;
    end

    @(negedge clk);
    chk("run_idle_we", {31'd0, rf_we}, 32'd0);
    for (int r = 1; r < 32; r++)
      chk("zero_fill", rd(5'(r)), 32'd0);

    // single load-unit write to x5
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'h0000_000A, 32'd0};
    #1 chk("r1_ready", {29'd0, req_ready}, 32'b010);
    @(negedge clk);
    req_valid = 3'b000;
    chk("r1_we", {31'd0, rf_we}, 32'd1);
    chk("r1_wa", {27'd0, rf_wa}, 32'd5);
    chk("r1_wd", rf_wd, 32'h0000_000A);
    chk("r1_lg", {30'd0, last_grant}, 32'd1);
    @(negedge clk);
    chk("r1_x5", rd(5'd5), 32'h0000_000A);
    chk("r1_we_off", {31'd0, rf_we}, 32'd0);

    // ptr is 2: write to x0 from mul/div is dropped
    req_valid = 3'b100;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'hFFFF_FFFF, 64'd0};
    #1 chk("x0_ready", {29'd0, req_ready}, 32'b100);
    @(negedge clk);
    req_valid = 3'b000;
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("x0_lg", {30'd0, last_grant}, 32'd2);
    chk("x0_rd", rd(5'd0), 32'd0);

    // ptr is 0: all three valid, rotate 0,1,2,0,1,2
    req_valid = 3'b111;
    req_addr  = {5'd12, 5'd11, 5'd10};
    req_data  = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    for (int j = 0; j < 6; j++) begin
      #1 chk("rr_ready", {29'd0, req_ready}, 32'(1 << (j % 3)));
      @(negedge clk);
      chk("rr_we", {31'd0, rf_we}, 32'd1);
      chk("rr_wa", {27'd0, rf_wa}, 32'(10 + j % 3));
      chk("rr_lg", {30'd0, last_grant}, 32'(j % 3));
    end
    req_valid = 3'b000;
    @(negedge clk);
    chk("rr_x10", rd(5'd10), 32'h0000_00C0);
    chk("rr_x11", rd(5'd11), 32'h0000_00C1);
    chk("rr_x12", rd(5'd12), 32'h0000_00C2);

    // move ptr to 1, then reqs 0 and 2 race for x20
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd3};
    req_data  = {64'd0, 32'h0000_0033};
    #1 chk("p1_ready", {29'd0, req_ready}, 32'b001);
    @(negedge clk);
    req_valid = 3'b101;
    req_addr  = {5'd20, 5'd0, 5'd20};
    req_data  = {32'h0000_0200, 32'd0, 32'h0000_0100};
    #1 chk("skip_ready2", {29'd0, req_ready}, 32'b100);
    @(negedge clk);
    chk("skip_lg2", {30'd0, last_grant}, 32'd2);
    chk("skip_wd2", rf_wd, 32'h0000_0200);
    #1 chk("skip_ready0", {29'd0, req_ready}, 32'b001);
    @(negedge clk);
    req_valid = 3'b000;
    chk("skip_lg0", {30'd0, last_grant}, 32'd0);
    chk("skip_wd0", rf_wd, 32'h0000_0100);
    @(negedge clk);
    chk("waw_x20", rd(5'd20), 32'h0000_0100);
    chk("x3", rd(5'd3), 32'h0000_0033);

    // reset 2ns after accepting a write to x7
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd7};
    req_data  = {64'd0, 32'h0000_0055};
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 3'b000;
    #1;
    chk("mr_we", {31'd0, rf_we}, 32'd0);
    chk("mr_wa", {27'd0, rf_wa}, 32'd0);
    chk("mr_done", {31'd0, init_done}, 32'd0);
    chk("mr_ready", {29'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 chk("mr_x7", rd(5'd7), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("re_we", {31'd0, rf_we}, 32'd1);
    chk("re_wa", {27'd0, rf_wa}, 32'd1);
    chk("re_done", {31'd0, init_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
